mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_arb_prio.sv | 18 +
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg: shared FSM/owner types and bus widths for mem_arbiter.
// Rev 1.0
package mem_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int INSN_W = 32;
  localparam int BE_W   = 8;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
endpackage
`default_nettype wire

// File: rtl/mem_arb_prio.sv
`default_nettype none
// mem_arb_prio: two-way combinational priority select, data over fetch unless force_if.
// Rev 1.0
module mem_arb_prio
  import mem_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  logic   force_if,
  output logic   if_gnt,
  output logic   d_gnt,
  output owner_t owner
);
  assign d_gnt  = d_req & ~(if_req & force_if);
  assign if_gnt = if_req & ~d_gnt;
  assign owner  = d_gnt ? OWN_D : OWN_IF;
endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: fetch/data arbiter onto one memory port, 1-cycle responses.
// Rev 1.0 -- define MEM_ARB_STARVE_GUARD_EN to enable the fetch starvation guard.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [INSN_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [BE_W-1:0]   d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [BE_W-1:0]   mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  logic   force_if;
  logic   if_win;
  logic   d_win;
  logic   if_gnt;
  logic   d_gnt;
  owner_t win_owner;
  state_t state;
  owner_t resp_owner;

  mem_arb_prio u_prio (
    .if_req   (if_req_i),
    .d_req    (d_req_i),
    .force_if (force_if),
    .if_gnt   (if_win),
    .d_gnt    (d_win),
    .owner    (win_owner)
  );

  // Grants are suppressed the moment reset asserts, not at the next edge.
  assign if_gnt   = if_win & rst_n;
  assign d_gnt    = d_win & rst_n;
  assign if_gnt_o = if_gnt;
  assign d_gnt_o  = d_gnt;

  assign mem_req_o   = if_gnt | d_gnt;
  assign mem_we_o    = d_gnt & d_we_i;
  assign mem_be_o    = d_gnt ? d_be_i : '0;
  assign mem_addr_o  = d_gnt ? d_addr_i : (if_gnt ? if_addr_i : '0);
  assign mem_wdata_o = d_gnt ? d_wdata_i : '0;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [CNT_W-1:0] starve_cnt;

  assign force_if = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req_i || if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`else
  // Pure fixed priority; STARVE_LIMIT has no effect in this build.
  assign force_if = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_owner <= OWN_IF;
      if_rdata_o <= '0;
      d_rdata_o  <= '0;
    end else begin
      case (state)
        IDLE:    if (mem_req_o) state <= RESP;
        RESP:    if (!mem_req_o) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (mem_req_o) resp_owner <= win_owner;
      if (d_gnt) d_rdata_o <= d_we_i ? '0 : mem_rdata_i;
      if (if_gnt) if_rdata_o <= if_addr_i[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    end
  end

  assign if_rvalid_o = (state == RESP) && (resp_owner == OWN_IF);
  assign d_rvalid_o  = (state == RESP) && (resp_owner == OWN_D);
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: scoreboard bench for mem_arbiter (default or guard build).
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [7:0]  d_be = '0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we;
  logic [7:0]  mem_be;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    bit          is_if;
    logic [63:0] data;
  } resp_t;

  resp_t sb[$];
  int total = 0;
  int bad = 0;
  int mdl_cnt = 0;
  int if_grants = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a[63:3] == 61'd0) return 64'h0640_2103_0610_2223;
    return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
  endfunction

  assign mem_rdata = mem_req ? mem_word(mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic check_resp();
    resp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("if_rvalid", if_rvalid, e.is_if);
      check("d_rvalid", d_rvalid, !e.is_if);
      if (e.is_if) check("if_rdata", if_rdata, e.data);
      else check("d_rdata", d_rdata, e.data);
    end else begin
      check("if_rvalid_idle", if_rvalid, 0);
      check("d_rvalid_idle", d_rvalid, 0);
    end
  endtask

  task automatic step(input logic ir, input logic [63:0] ia, input logic dr, input logic dwe,
                      input logic [7:0] dbe, input logic [63:0] da, input logic [63:0] dwd);
    bit force_f, eg_d, eg_i;
    resp_t r;
    logic [63:0] w;
    @(posedge clk);
    #1;
    check_resp();
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    #2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_f = ir && (mdl_cnt >= LIMIT);
`else
    force_f = 1'b0;
`endif
    eg_d = dr && !force_f;
    eg_i = ir && !eg_d;
    check("if_gnt", if_gnt, eg_i);
    check("d_gnt", d_gnt, eg_d);
    check("mem_req", mem_req, eg_d || eg_i);
    check("mem_we", mem_we, eg_d && dwe);
    check("mem_be", mem_be, eg_d ? dbe : 8'h00);
    check("mem_addr", mem_addr, eg_d ? da : (eg_i ? ia : 64'd0));
    check("mem_wdata", mem_wdata, eg_d ? dwd : 64'd0);
    if (!ir || eg_i) mdl_cnt = 0;
    else if (eg_d) mdl_cnt++;
    if (eg_d) begin
      r.is_if = 1'b0;
      r.data = dwe ? 64'd0 : mem_word(da);
      sb.push_back(r);
    end else if (eg_i) begin
      if_grants++;
      w = mem_word(ia);
      r.is_if = 1'b1;
      r.data = {32'd0, ia[2] ? w[63:32] : w[31:0]};
      sb.push_back(r);
    end
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #10;
    check("rst_if_gnt", if_gnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    rst_n = 1'b1;
    idle();

    // Fetch only from 0x4: upper half of the first memory word
    step(1'b1, 64'h4, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0);
    idle();
    check("fetch_word", if_rdata, 64'h0640_2103);

    // Both request: data first, then fetch
    step(1'b1, 64'h10, 1'b1, 1'b0, 8'hFF, 64'h64, 64'd0);
    step(1'b1, 64'h10, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0);
    idle();

    // Data write
    step(1'b0, 64'd0, 1'b1, 1'b1, 8'h0F, 64'h64, 64'd5);
    idle();

    // Back-to-back data reads
    step(1'b0, 64'd0, 1'b1, 1'b0, 8'hFF, 64'h0, 64'd0);
    step(1'b0, 64'd0, 1'b1, 1'b0, 8'hFF, 64'h8, 64'd0);
    check("state_b2b1", dut.state, RESP);
    step(1'b0, 64'd0, 1'b1, 1'b0, 8'hFF, 64'h10, 64'd0);
    check("state_b2b2", dut.state, RESP);
    idle();
    check("state_last", dut.state, RESP);
    idle();
    check("state_idle", dut.state, IDLE);

    // Continuous contention
    if_grants = 0;
    for (int i = 0; i < 15; i++)
      step(1'b1, 64'h28, 1'b1, 1'b0, 8'hFF, 64'h20, 64'd0);
    idle();
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("fetch_grants", if_grants, 3);
`else
    check("fetch_grants", if_grants, 0);
`endif
    idle();

    // Reset asserted inside a grant cycle
    @(posedge clk);
    #1;
    check_resp();
    if_req = 1'b1; if_addr = 64'h8;
    #2;
    check("pre_rst_gnt", if_gnt, 1);
    rst_n = 1'b0;
    #1;
    check("async_if_gnt", if_gnt, 0);
    check("async_mem_req", mem_req, 0);
    check("async_mem_addr", mem_addr, 0);
    check("async_if_rdata", if_rdata, 0);
    check("async_d_rdata", d_rdata, 0);
    if_req = 1'b0; if_addr = '0;
    mdl_cnt = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle();
    step(1'b1, 64'h8, 1'b0, 1'b0, 8'h00, 64'd0, 64'd0);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
